// File: rtl/simd_pkg.sv
// Shared types, opcode constants and decode helper for the SIMD issue controller.
package simd_pkg;

    typedef enum logic [2:0] {
        TYPE_NOP  = 3'd0,
        TYPE_SUB  = 3'd1,
        TYPE_MUL  = 3'd2,
        TYPE_ADD  = 3'd3,
        TYPE_FADD = 3'd4,
        TYPE_FSUB = 3'd5,
        TYPE_LOAD = 3'd6
    } instr_type_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEMWAIT = 3'd4
    } state_e;

    localparam logic [10:0] OPC_NOP  = 11'b00000000000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_MUL  = 11'b10011011000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_FP   = 11'b00011110011;
    localparam logic [10:0] OPC_LOAD = 11'b10101010101;

    localparam logic [5:0] FP_ADD_CODE = 6'b001010;
    localparam logic [5:0] FP_SUB_CODE = 6'b001110;

    localparam logic [31:0] RET_WORD = 32'hD65F03C0;

    // FP ops share one major opcode and are told apart by bits [15:10].
    function automatic instr_type_e decode_type(input logic [31:0] word);
        instr_type_e t;
        case (word[31:21])
            OPC_NOP:  t = TYPE_NOP;
            OPC_SUB:  t = TYPE_SUB;
            OPC_MUL:  t = TYPE_MUL;
            OPC_ADD:  t = TYPE_ADD;
            OPC_LOAD: t = TYPE_LOAD;
            OPC_FP: begin
                if (word[15:10] == FP_ADD_CODE) begin
                    t = TYPE_FADD;
                end else if (word[15:10] == FP_SUB_CODE) begin
                    t = TYPE_FSUB;
                end else begin
                    t = TYPE_NOP;
                end
            end
            default:  t = TYPE_NOP;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/simd_latency_timer.sv
// Down-counter loaded on issue; expire_o is high during the last cycle of the loaded latency.
module simd_latency_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] count_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         expire_q;

    // next count: reload on issue, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = count_i;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count and expire registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= {W{1'b0}};
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= (cnt_d == W'(1));
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/simd_issue_ctrl.sv
// SIMD kernel fetch/issue sequencer with multi-cycle execute and special-load wait.
// Optional performance counters are enabled by defining SIMD_PERF_CNT_EN.
module simd_issue_ctrl
    import simd_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int MUL_LAT = 3,
    parameter int FP_LAT  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] base_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic            issue_valid,
    output logic [2:0]      issue_type,
    output logic [31:0]     issue_instr,
    output logic            mem_req,
    input  logic            mem_done,
    output logic            busy,
    output logic            done
`ifdef SIMD_PERF_CNT_EN
    ,
    output logic [15:0]     cycle_cnt,
    output logic [15:0]     instr_cnt
`endif
);

    localparam int LAT_MAX = (MUL_LAT > FP_LAT) ? MUL_LAT : FP_LAT;
    localparam int TMR_W   = $clog2(LAT_MAX + 1);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              imem_req_q, imem_req_d;
    logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
    logic              issue_valid_q, issue_valid_d;
    logic [2:0]        issue_type_q, issue_type_d;
    logic [31:0]       issue_instr_q, issue_instr_d;
    logic              mem_req_q, mem_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    instr_type_e       fetch_type_s, cur_type_s;
    logic              fetch_ret_s, cur_ret_s;
    logic              tmr_load_s, tmr_expire_s;
    logic [TMR_W-1:0]  tmr_count_s;

    assign fetch_type_s = decode_type(imem_rdata);
    assign fetch_ret_s  = (imem_rdata == RET_WORD);
    assign cur_type_s   = decode_type(instr_q);
    assign cur_ret_s    = (instr_q == RET_WORD);

    simd_latency_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tmr_load_s),
        .count_i  (tmr_count_s),
        .expire_o (tmr_expire_s)
    );

    // Next state; issue outputs are computed at fetch so they line up with the ISSUE cycle.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        busy_d        = busy_q;
        issue_valid_d = 1'b0;
        done_d        = 1'b0;
        issue_type_d  = issue_type_q;
        issue_instr_d = issue_instr_q;
        tmr_load_s    = 1'b0;
        tmr_count_s   = {TMR_W{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = base_pc;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = ST_ISSUE;
                    if (fetch_ret_s) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        issue_valid_d = 1'b1;
                        issue_type_d  = fetch_type_s;
                        issue_instr_d = imem_rdata;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (cur_ret_s) begin
                    state_d = ST_IDLE;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                    case (cur_type_s)
                        TYPE_MUL: begin
                            tmr_load_s  = 1'b1;
                            tmr_count_s = TMR_W'(MUL_LAT);
                            state_d     = ST_EXEC;
                        end
                        TYPE_FADD, TYPE_FSUB: begin
                            tmr_load_s  = 1'b1;
                            tmr_count_s = TMR_W'(FP_LAT);
                            state_d     = ST_EXEC;
                        end
                        TYPE_LOAD: state_d = ST_MEMWAIT;
                        default:   state_d = ST_FETCH;
                    endcase
                end
            end
            ST_EXEC: begin
                if (tmr_expire_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_MEMWAIT: begin
                if (mem_done) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEMWAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        imem_req_d  = (state_d == ST_FETCH);
        imem_addr_d = pc_d;
        mem_req_d   = (state_d == ST_MEMWAIT);
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= {PC_W{1'b0}};
            instr_q       <= 32'd0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= {PC_W{1'b0}};
            issue_valid_q <= 1'b0;
            issue_type_q  <= 3'd0;
            issue_instr_q <= 32'd0;
            mem_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            issue_valid_q <= issue_valid_d;
            issue_type_q  <= issue_type_d;
            issue_instr_q <= issue_instr_d;
            mem_req_q     <= mem_req_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign issue_valid = issue_valid_q;
    assign issue_type  = issue_type_q;
    assign issue_instr = issue_instr_q;
    assign mem_req     = mem_req_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef SIMD_PERF_CNT_EN
    logic [15:0] cycle_cnt_q, instr_cnt_q;

    // saturating busy-cycle and issue counters, cleared on an accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q <= 16'd0;
            instr_cnt_q <= 16'd0;
        end else if ((state_q == ST_IDLE) && start) begin
            cycle_cnt_q <= 16'd0;
            instr_cnt_q <= 16'd0;
        end else begin
            if (busy_q && (cycle_cnt_q != 16'hFFFF)) begin
                cycle_cnt_q <= cycle_cnt_q + 16'd1;
            end else begin
                cycle_cnt_q <= cycle_cnt_q;
            end
            if (issue_valid_q && (instr_cnt_q != 16'hFFFF)) begin
                instr_cnt_q <= instr_cnt_q + 16'd1;
            end else begin
                instr_cnt_q <= instr_cnt_q;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Directed self-checking bench for simd_issue_ctrl.
module tb_simd_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        issue_valid;
    logic [2:0]  issue_type;
    logic [31:0] issue_instr;
    logic        mem_req;
    logic        mem_done;
    logic        busy;
    logic        done;
`ifdef SIMD_PERF_CNT_EN
    logic [15:0] cycle_cnt;
    logic [15:0] instr_cnt;
`endif

    logic [31:0] imem [0:255];
    int vec;
    int errs;

    localparam logic [31:0] W_ADD  = {11'b10001011000, 21'd5};
    localparam logic [31:0] W_SUB  = {11'b11001011000, 21'd9};
    localparam logic [31:0] W_MUL  = {11'b10011011000, 21'd3};
    localparam logic [31:0] W_FADD = {11'b00011110011, 5'd1, 6'b001010, 10'd7};
    localparam logic [31:0] W_FSUB = {11'b00011110011, 5'd2, 6'b001110, 10'd7};
    localparam logic [31:0] W_LOAD = {11'b10101010101, 21'd1};
    localparam logic [31:0] W_NOP  = 32'd0;
    localparam logic [31:0] W_RET  = 32'hD65F03C0;

    simd_issue_ctrl #(.PC_W(8), .MUL_LAT(3), .FP_LAT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_pc     (base_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .issue_valid (issue_valid),
        .issue_type  (issue_type),
        .issue_instr (issue_instr),
        .mem_req     (mem_req),
        .mem_done    (mem_done),
        .busy        (busy),
        .done        (done)
`ifdef SIMD_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
        imem_rdata = imem[imem_addr];
    endtask

    task automatic launch(input logic [7:0] pc);
        base_pc = pc;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; base_pc = 8'h33; imem_valid = 1'b1; mem_done = 1'b0;
        step(); step();
        vec++; if (busy !== 1'b0)        begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vec++; if (imem_req !== 1'b0)    begin errs++; $display("FAIL reset_imem_req got %b want 0", imem_req); end
        vec++; if ({issue_valid, done, mem_req} !== 3'b000) begin errs++; $display("FAIL reset_pulses got %b want 000", {issue_valid, done, mem_req}); end
        vec++; if ({imem_addr, issue_type, issue_instr} !== 43'd0) begin errs++; $display("FAIL reset_data got %h/%h/%h want 0", imem_addr, issue_type, issue_instr); end
        rst_n = 1'b1; start = 1'b0;
        step();
        vec++; if ({busy, imem_req} !== 2'b00) begin errs++; $display("FAIL reset_start_ignored got %b want 00", {busy, imem_req}); end
    endtask

    task automatic test_basic();
        int n_iss = 0; int done_c = -1; int iss_c0 = -1; int iss_c1 = -1;
        logic [7:0] last_addr = 8'h00;
        imem[8'h10] = W_ADD; imem[8'h11] = W_SUB; imem[8'h12] = W_RET;
        imem_valid = 1'b1;
        launch(8'h10);
        for (int c = 0; c < 40 && done_c < 0; c++) begin
            if (issue_valid) begin
                n_iss++;
                if (n_iss == 1) begin
                    iss_c0 = c;
                    vec++; if ({last_addr, issue_type, issue_instr} !== {8'h10, 3'd3, W_ADD}) begin errs++; $display("FAIL basic_issue0 got %h/%0d/%h want 10/3/%h", last_addr, issue_type, issue_instr, W_ADD); end
                end else begin
                    iss_c1 = c;
                    vec++; if ({last_addr, issue_type, issue_instr} !== {8'h11, 3'd1, W_SUB}) begin errs++; $display("FAIL basic_issue1 got %h/%0d/%h want 11/1/%h", last_addr, issue_type, issue_instr, W_SUB); end
                end
            end
            if (done) begin
                done_c = c;
                vec++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
            end
            if (imem_req) last_addr = imem_addr;
            step();
        end
        vec++; if (n_iss !== 2) begin errs++; $display("FAIL basic_issue_count got %0d want 2", n_iss); end
        vec++; if ({iss_c0, iss_c1, done_c} !== {32'sd1, 32'sd3, 32'sd5}) begin errs++; $display("FAIL basic_timing got %0d,%0d,%0d want 1,3,5", iss_c0, iss_c1, done_c); end
        vec++; if ({busy, imem_req, done, issue_type} !== {3'b000, 3'd1}) begin errs++; $display("FAIL basic_idle_hold got %b/%b/%b/%0d want 0/0/0/1", busy, imem_req, done, issue_type); end
    endtask

    task automatic test_exec(input logic [31:0] w0, input logic [31:0] w1, input logic [2:0] t0,
                             input logic [2:0] t1, input int gap, input string name);
        int n_iss = 0; int c0 = -1; int c1 = -1; int done_c = -1; int req_cnt = 0;
        imem[8'h20] = w0; imem[8'h21] = w1; imem[8'h22] = W_RET;
        launch(8'h20);
        for (int c = 0; c < 60 && done_c < 0; c++) begin
            if (issue_valid) begin
                n_iss++;
                if (n_iss == 1) c0 = c; else c1 = c;
                vec++; if (issue_type !== ((n_iss == 1) ? t0 : t1)) begin errs++; $display("FAIL %s_type%0d got %0d want %0d", name, n_iss, issue_type, (n_iss == 1) ? t0 : t1); end
            end
            if (imem_req) req_cnt++;
            if (done) done_c = c;
            step();
        end
        vec++; if ((c1 - c0) !== gap) begin errs++; $display("FAIL %s_gap got %0d want %0d", name, c1 - c0, gap); end
        vec++; if (req_cnt !== 3) begin errs++; $display("FAIL %s_fetch_cycles got %0d want 3", name, req_cnt); end
        vec++; if (done_c < 0) begin errs++; $display("FAIL %s_done got timeout want done", name); end
    endtask

    task automatic test_load();
        int n_iss = 0; int mcnt = 0; bit chk = 1'b0; bit seen_done = 1'b0;
        imem[8'h30] = W_LOAD; imem[8'h31] = W_ADD; imem[8'h32] = W_RET;
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        launch(8'h30);
        for (int c = 0; c < 60 && !seen_done; c++) begin
            if (chk) begin
                chk = 1'b0;
                vec++; if ({imem_req, mem_req} !== 2'b10) begin errs++; $display("FAIL load_refetch got req=%b mem_req=%b want 1/0", imem_req, mem_req); end
            end
            if (issue_valid) begin
                n_iss++;
                vec++; if (issue_type !== ((n_iss == 1) ? 3'd6 : 3'd3)) begin errs++; $display("FAIL load_type%0d got %0d", n_iss, issue_type); end
            end
            if (mem_req) begin
                mcnt++;
                if (mcnt == 7) begin mem_done = 1'b1; chk = 1'b1; end
            end
            if (done) seen_done = 1'b1;
            step();
            mem_done = 1'b0;
        end
        vec++; if (mcnt !== 7) begin errs++; $display("FAIL load_mem_req_cycles got %0d want 7", mcnt); end
        vec++; if ({seen_done, n_iss} !== {1'b1, 32'sd2}) begin errs++; $display("FAIL load_completion got done=%b issues=%0d want 1/2", seen_done, n_iss); end
    endtask

    task automatic test_wrap();
        int n_acc = 0; bit seen_done = 1'b0;
        logic [7:0] got [0:2];
        imem[8'hFF] = W_ADD; imem[8'h00] = W_ADD; imem[8'h01] = W_RET;
        imem_valid = 1'b0;
        launch(8'hFF);
        for (int c = 0; c < 40 && !seen_done; c++) begin
            imem_valid = (c >= 3);
            if (c < 3) begin
                vec++; if ({imem_req, issue_valid} !== 2'b10) begin errs++; $display("FAIL wrap_fetch_wait got %b want 10", {imem_req, issue_valid}); end
            end
            if (imem_req && imem_valid && n_acc < 3) begin got[n_acc] = imem_addr; n_acc++; end
            if (done) seen_done = 1'b1;
            step();
        end
        imem_valid = 1'b1;
        vec++; if ({n_acc, got[0], got[1], got[2]} !== {32'sd3, 8'hFF, 8'h00, 8'h01}) begin errs++; $display("FAIL wrap_addrs got n=%0d %h %h %h want 3 FF 00 01", n_acc, got[0], got[1], got[2]); end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0; bit bad = 1'b0; int n_iss = 0; bit seen_done = 1'b0;
        imem[8'h40] = W_FADD; imem[8'h41] = W_ADD; imem[8'h42] = W_RET;
        launch(8'h40);
        for (int c = 0; c < 10 && !found; c++) begin
            if (issue_valid) found = 1'b1; else step();
        end
        vec++; if ({found, issue_type} !== {1'b1, 3'd4}) begin errs++; $display("FAIL mid_fadd_issue got found=%b type=%0d want 1/4", found, issue_type); end
        step(); step();
        rst_n = 1'b0; start = 1'b1;
        step();
        vec++; if ({busy, imem_req, issue_valid, done, mem_req, issue_type, imem_addr} !== 16'd0) begin errs++; $display("FAIL mid_reset_outputs got %b%b%b%b%b/%0d/%h want all 0", busy, imem_req, issue_valid, done, mem_req, issue_type, imem_addr); end
        rst_n = 1'b1; start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (done || busy || issue_valid) bad = 1'b1;
            step();
        end
        vec++; if (bad !== 1'b0) begin errs++; $display("FAIL mid_quiet_after_reset got activity want none"); end
        launch(8'h10);
        for (int c = 0; c < 30 && !seen_done; c++) begin
            if (issue_valid) n_iss++;
            if (done) seen_done = 1'b1;
            step();
        end
        vec++; if ({seen_done, n_iss} !== {1'b1, 32'sd2}) begin errs++; $display("FAIL mid_restart got done=%b issues=%0d want 1/2", seen_done, n_iss); end
    endtask

`ifdef SIMD_PERF_CNT_EN
    task automatic test_perf();
        int busy_cycles = 0; bit seen_done = 1'b0;
        imem[8'h50] = W_ADD; imem[8'h51] = W_SUB; imem[8'h52] = W_ADD; imem[8'h53] = W_NOP; imem[8'h54] = W_RET;
        launch(8'h50);
        for (int c = 0; c < 40 && !seen_done; c++) begin
            if (busy) busy_cycles++;
            if (done) seen_done = 1'b1;
            step();
        end
        step();
        vec++; if (instr_cnt !== 16'd4) begin errs++; $display("FAIL perf_instr_cnt got %0d want 4", instr_cnt); end
        vec++; if ({cycle_cnt, busy_cycles} !== {16'd9, 32'sd9}) begin errs++; $display("FAIL perf_cycle_cnt got %0d (busy %0d) want 9", cycle_cnt, busy_cycles); end
    endtask
`endif

    initial begin
        vec = 0; errs = 0;
        for (int i = 0; i < 256; i++) imem[i] = W_NOP;
        rst_n = 1'b0; start = 1'b0; base_pc = 8'h00; imem_valid = 1'b1; mem_done = 1'b0; imem_rdata = 32'd0;
        test_reset();
        test_basic();
        test_exec(W_MUL, W_ADD, 3'd2, 3'd3, 5, "mul");
        test_exec(W_FADD, W_FSUB, 3'd4, 3'd5, 6, "fp");
        test_load();
        test_wrap();
        test_reset_mid();
`ifdef SIMD_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/simd_issue_ctrl.md
SIMD_ISSUE_CTRL -- requirements
Module: simd_issue_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 8, instruction address width.
REQ-002 SHALL have parameter MUL_LAT, default 3, MUL execute cycles (>=1).
REQ-003 SHALL have parameter FP_LAT, default 4, FADD/FSUB execute cycles (>=1).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port start, input, 1, one-cycle kernel launch pulse.
REQ-007 SHALL have port base_pc, input, PC_W, first instruction address, sampled on accepted start.
REQ-008 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-009 SHALL have port imem_addr, output, PC_W, fetch address.
REQ-010 SHALL have port imem_valid, input, 1, fetch data valid.
REQ-011 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-012 SHALL have port issue_valid, output, 1, one-cycle pulse issuing an instruction to all lanes.
REQ-013 SHALL have port issue_type, output, 3, instruction type code.
REQ-014 SHALL have port issue_instr, output, 32, issued instruction word.
REQ-015 SHALL have port mem_req, output, 1, special-load request, held until mem_done.
REQ-016 SHALL have port mem_done, input, 1, special-load completion.
REQ-017 SHALL have port busy, output, 1, kernel in progress.
REQ-018 SHALL have port done, output, 1, one-cycle kernel-complete pulse.

Function
REQ-019 SHALL decode types from bits [31:21]: 00000000000 NOP=0, 11001011000 SUB=1, 10011011000 MUL=2, 10001011000 ADD=3, 00011110011 with [15:10]=001010 FADD=4, 00011110011 with [15:10]=001110 FSUB=5, 10101010101 LOAD=6; all else NOP=0.
REQ-020 SHALL treat word 32'hD65F03C0 as RET (halt); RET is never issued.
REQ-021 SHALL implement FSM IDLE, FETCH, ISSUE, EXEC, MEMWAIT.
REQ-022 IDLE: start -> FETCH, pc<=base_pc, busy<=1; start ignored in every other state.
REQ-023 FETCH: imem_req=1, imem_addr=pc; on imem_valid latch word -> ISSUE; wait indefinitely otherwise.
REQ-024 ISSUE (one cycle): RET -> IDLE with done=1, busy=0; else issue_valid=1, pc<=pc+1, then NOP/ADD/SUB -> FETCH, MUL/FADD/FSUB -> EXEC, LOAD -> MEMWAIT.
REQ-025 EXEC: stay exactly MUL_LAT (MUL) or FP_LAT (FADD/FSUB) cycles after ISSUE, then FETCH.
REQ-026 MEMWAIT: mem_req=1; on mem_done -> FETCH next cycle; mem_done outside MEMWAIT ignored.
REQ-027 issue_type/issue_instr SHALL hold last issued values between issues.
REQ-028 pc SHALL wrap modulo 2^PC_W with no error.
REQ-029 imem_valid outside FETCH SHALL be ignored.
REQ-030 Minimum single-cycle-op throughput SHALL be one issue per 2 cycles with imem_valid tied high.

Reset
REQ-031 rst_n low at a clock edge SHALL force IDLE, pc=0, timer=0, and all outputs 0, aborting any fetch, execute or load mid-operation; no done pulse.
REQ-032 start sampled in the same cycle as rst_n low SHALL be ignored.

Configuration
REQ-033 Macro SIMD_PERF_CNT_EN SHALL add outputs cycle_cnt[15:0] (busy cycles) and instr_cnt[15:0] (issues), cleared on accepted start and reset, saturating at 16'hFFFF, held after done.
REQ-034 Without SIMD_PERF_CNT_EN the ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-035 Package simd_pkg SHALL hold the type enum (NOP..LOAD), 11-bit opcode constants, FP [15:10] codes, RET word constant, FSM state enum.
REQ-036 Sub-module simd_latency_timer SHALL load a count on ISSUE and assert expire after that many cycles.

Verification
REQ-037 start, base_pc=8'h10, words ADD, SUB, RET, imem_valid high -> issue_valid at addresses 10,11; types 3,1; done 1 cycle after RET fetch; busy 0.
REQ-038 MUL_LAT=3, MUL then ADD -> ADD issue_valid exactly 5 cycles after MUL issue_valid (3 EXEC + FETCH + ISSUE).
REQ-039 LOAD, mem_done after 7 cycles -> mem_req high 7 cycles, next imem_req the cycle after mem_done.
REQ-040 base_pc=8'hFF, ADD, ADD, RET -> fetch addresses FF, 00, 01.
REQ-041 rst_n low during FP EXEC -> next cycle IDLE, all outputs 0, no done; new start runs cleanly.
REQ-042 SIMD_PERF_CNT_EN, 4 issues + RET -> instr_cnt=4, cycle_cnt equals busy-high cycles.
